fp_operand_issuer: RTL and testbench

- Upstream feeder for the floating-point adder/multiplier cores.
- Buffers operand pairs from the control logic in a small FIFO, then drives the cores' AXI-Stream A and B slave channels with correct per-channel handshaking.
- Credit-limits outstanding operations so the result channel never overflows downstream storage.
- Forwards the core's result stream downstream and tracks in-flight count.

---
 rtl/fp_operand_issuer.sv | 181 ++++++++++++++++++
 tb/tb_fp_operand_issuer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_operand_issuer.sv
// Operand-pair feeder for the floating-point cores: buffers pairs in a FIFO, issues them on
// independent A/B AXI-Stream channels under a credit limit, and passes results straight through.
module fp_operand_issuer #(
    parameter int DATA_W          = 32,
    parameter int DEPTH           = 8,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_W-1:0]                  in_a,
    input  logic [DATA_W-1:0]                  in_b,
    output logic                               s_axis_a_tvalid,
    input  logic                               s_axis_a_tready,
    output logic [DATA_W-1:0]                  s_axis_a_tdata,
    output logic                               s_axis_b_tvalid,
    input  logic                               s_axis_b_tready,
    output logic [DATA_W-1:0]                  s_axis_b_tdata,
    input  logic                               m_axis_result_tvalid,
    output logic                               m_axis_result_tready,
    input  logic [DATA_W-1:0]                  m_axis_result_tdata,
    output logic                               res_valid,
    output logic [DATA_W-1:0]                  res_data,
    input  logic                               res_ready,
    output logic [$clog2(DEPTH):0]             fifo_level,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               err_unexpected
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t            state_q, state_d;

    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     level_q;

    logic [OW-1:0]     out_q;
    logic              err_q;

    logic              a_valid_q, b_valid_q;
    logic [DATA_W-1:0] a_data_q, b_data_q;

    logic              push, load, fifo_empty, head_avail;
    logic [DATA_W-1:0] head_a, head_b;
    logic              a_done, b_done, retire, credit_ok;
    logic              res_hs, res_dec;

    // ------------------------------------------------------------------
    // Operand-pair FIFO. An empty FIFO forwards the incoming pair so the
    // issue stage can load it in the same cycle it is pushed.
    // ------------------------------------------------------------------
    assign in_ready   = (level_q < LW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign fifo_empty = (level_q == '0);
    assign head_avail = !fifo_empty || push;
    assign head_a     = fifo_empty ? in_a : mem_a[rd_ptr];
    assign head_b     = fifo_empty ? in_b : mem_b[rd_ptr];

    // NOTE: the storage array carries no reset; validity is tracked by the pointers and level alone.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    // NOTE: every clocked block uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (load) rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, load})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Issue control. A retiring pair is counted into the credit check so
    // a same-cycle reload can never push outstanding past the limit.
    // ------------------------------------------------------------------
    assign a_done    = !a_valid_q || s_axis_a_tready;
    assign b_done    = !b_valid_q || s_axis_b_tready;
    assign retire    = (state_q == ISSUE) && a_done && b_done;
    assign credit_ok = ({1'b0, out_q} + {{OW{1'b0}}, retire}) < (OW + 1)'(MAX_OUTSTANDING);

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (head_avail && credit_ok) begin
                    load    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (retire) begin
                    if (head_avail && credit_ok) load    = 1'b1;
                    else                         state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Each channel drops its own valid on its handshake; data holds until reload.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            a_data_q  <= '0;
            b_data_q  <= '0;
        end else if (load) begin
            a_valid_q <= 1'b1;
            b_valid_q <= 1'b1;
            a_data_q  <= head_a;
            b_data_q  <= head_b;
        end else begin
            if (a_valid_q && s_axis_a_tready) a_valid_q <= 1'b0;
            if (b_valid_q && s_axis_b_tready) b_valid_q <= 1'b0;
        end
    end

    assign s_axis_a_tvalid = a_valid_q;
    assign s_axis_a_tdata  = a_data_q;
    assign s_axis_b_tvalid = b_valid_q;
    assign s_axis_b_tdata  = b_data_q;

    // ------------------------------------------------------------------
    // Result pass-through and in-flight accounting.
    // ------------------------------------------------------------------
    assign res_valid            = m_axis_result_tvalid;
    assign res_data             = m_axis_result_tdata;
    assign m_axis_result_tready = res_ready;

    assign res_hs  = m_axis_result_tvalid && res_ready;
    assign res_dec = res_hs && (out_q != '0);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_q <= '0;
            err_q <= 1'b0;
        end else begin
            unique case ({retire, res_dec})
                2'b10:   out_q <= out_q + OW'(1);
                2'b01:   out_q <= out_q - OW'(1);
                default: out_q <= out_q;
            endcase
            // A result with nothing in flight is a core protocol fault; latch it until reset.
            if (res_hs && (out_q == '0)) err_q <= 1'b1;
        end
    end

    assign fifo_level     = level_q;
    assign outstanding    = out_q;
    assign err_unexpected = err_q;

endmodule

// File: tb/tb_fp_operand_issuer.sv
// Directed, table-driven bench for fp_operand_issuer: handshake timing, FIFO fill,
// credit limiting, result accounting and asynchronous reset.
module tb_fp_operand_issuer;

    localparam int DATA_W = 32;

    logic              aclk;
    logic              aresetn;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a, in_b;
    logic              s_axis_a_tvalid, s_axis_a_tready;
    logic [DATA_W-1:0] s_axis_a_tdata;
    logic              s_axis_b_tvalid, s_axis_b_tready;
    logic [DATA_W-1:0] s_axis_b_tdata;
    logic              m_axis_result_tvalid, m_axis_result_tready;
    logic [DATA_W-1:0] m_axis_result_tdata;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;
    logic [3:0]        fifo_level;
    logic [4:0]        outstanding;
    logic              err_unexpected;

    fp_operand_issuer #(.DATA_W(DATA_W), .DEPTH(8), .MAX_OUTSTANDING(16)) dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_a                 (in_a),
        .in_b                 (in_b),
        .s_axis_a_tvalid      (s_axis_a_tvalid),
        .s_axis_a_tready      (s_axis_a_tready),
        .s_axis_a_tdata       (s_axis_a_tdata),
        .s_axis_b_tvalid      (s_axis_b_tvalid),
        .s_axis_b_tready      (s_axis_b_tready),
        .s_axis_b_tdata       (s_axis_b_tdata),
        .m_axis_result_tvalid (m_axis_result_tvalid),
        .m_axis_result_tready (m_axis_result_tready),
        .m_axis_result_tdata  (m_axis_result_tdata),
        .res_valid            (res_valid),
        .res_data             (res_data),
        .res_ready            (res_ready),
        .fifo_level           (fifo_level),
        .outstanding          (outstanding),
        .err_unexpected       (err_unexpected)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic        iv;
        logic [31:0] a, b;
        logic        ar, br, rv;
        logic [31:0] rd;
        logic        rr;
        logic        e_ir, e_av, e_bv;
        logic [31:0] e_ad, e_bd;
        logic [3:0]  e_lvl;
        logic [4:0]  e_out;
        logic        e_err;
    } vec_t;

    localparam logic [31:0] OPA = 32'h45bf70fc, OPB = 32'h40998b1a;
    localparam logic [31:0] OPC = 32'h3f800000, OPD = 32'hc0490fdb;
    localparam logic [31:0] RS1 = 32'h461c4000, RS2 = 32'hbf000000;
    localparam int NV = 13;

    vec_t tbl [NV];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   issue_cnt = 0;
    int   base;

    always @(negedge aclk) begin
        if (s_axis_a_tvalid && s_axis_a_tready) issue_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    function automatic vec_t mk(input logic iv, input logic [31:0] a, input logic [31:0] b,
                                input logic ar, input logic br, input logic rv,
                                input logic [31:0] rd, input logic rr,
                                input logic e_ir, input logic e_av, input logic e_bv,
                                input logic [31:0] e_ad, input logic [31:0] e_bd,
                                input logic [3:0] e_lvl, input logic [4:0] e_out, input logic e_err);
        vec_t v;
        v.iv = iv; v.a = a; v.b = b; v.ar = ar; v.br = br; v.rv = rv; v.rd = rd; v.rr = rr;
        v.e_ir = e_ir; v.e_av = e_av; v.e_bv = e_bv; v.e_ad = e_ad; v.e_bd = e_bd;
        v.e_lvl = e_lvl; v.e_out = e_out; v.e_err = e_err;
        return v;
    endfunction

    task automatic drive(input logic iv, input logic [31:0] a, input logic [31:0] b,
                         input logic ar, input logic br, input logic rv, input logic rr);
        in_valid = iv; in_a = a; in_b = b;
        s_axis_a_tready = ar; s_axis_b_tready = br;
        m_axis_result_tvalid = rv; m_axis_result_tdata = RS1; res_ready = rr;
    endtask

    initial begin
        aresetn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);

        //          iv  a    b    ar br rv rd   rr | ir av bv ad   bd   lvl out err
        tbl[0]  = mk(1, OPA, OPB, 1, 1, 0, 0,   0,  1, 0, 0, 0,   0,   0,  0,  0);
        tbl[1]  = mk(0, 0,   0,   1, 1, 0, 0,   0,  1, 1, 1, OPA, OPB, 0,  0,  0);
        tbl[2]  = mk(0, 0,   0,   1, 1, 1, RS1, 1,  1, 0, 0, OPA, OPB, 0,  1,  0);
        tbl[3]  = mk(0, 0,   0,   1, 1, 0, 0,   0,  1, 0, 0, OPA, OPB, 0,  0,  0);
        tbl[4]  = mk(1, OPC, OPD, 1, 0, 0, 0,   0,  1, 0, 0, OPA, OPB, 0,  0,  0);
        tbl[5]  = mk(0, 0,   0,   1, 0, 0, 0,   0,  1, 1, 1, OPC, OPD, 0,  0,  0);
        tbl[6]  = mk(0, 0,   0,   1, 0, 0, 0,   0,  1, 0, 1, OPC, OPD, 0,  0,  0);
        tbl[7]  = mk(0, 0,   0,   1, 0, 0, 0,   0,  1, 0, 1, OPC, OPD, 0,  0,  0);
        tbl[8]  = mk(0, 0,   0,   1, 0, 0, 0,   0,  1, 0, 1, OPC, OPD, 0,  0,  0);
        tbl[9]  = mk(0, 0,   0,   1, 0, 0, 0,   0,  1, 0, 1, OPC, OPD, 0,  0,  0);
        tbl[10] = mk(0, 0,   0,   1, 1, 0, 0,   0,  1, 0, 1, OPC, OPD, 0,  0,  0);
        tbl[11] = mk(0, 0,   0,   1, 1, 1, RS2, 1,  1, 0, 0, OPC, OPD, 0,  1,  0);
        tbl[12] = mk(0, 0,   0,   1, 1, 0, 0,   0,  1, 0, 0, OPC, OPD, 0,  0,  0);

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        check("rst a_tvalid", 32'(s_axis_a_tvalid), 0);
        check("rst b_tvalid", 32'(s_axis_b_tvalid), 0);
        check("rst a_tdata", s_axis_a_tdata, 0);
        check("rst fifo_level", 32'(fifo_level), 0);
        check("rst outstanding", 32'(outstanding), 0);
        check("rst err", 32'(err_unexpected), 0);
        @(negedge aclk);
        aresetn = 1'b1;
        cyc();
        check("rst in_ready", 32'(in_ready), 1);

        // Single pair and split acceptance, cycle by cycle
        for (int i = 0; i < NV; i++) begin
            in_valid = tbl[i].iv; in_a = tbl[i].a; in_b = tbl[i].b;
            s_axis_a_tready = tbl[i].ar; s_axis_b_tready = tbl[i].br;
            m_axis_result_tvalid = tbl[i].rv; m_axis_result_tdata = tbl[i].rd;
            res_ready = tbl[i].rr;
            #1;
            check($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            check($sformatf("row%0d a_tvalid", i), 32'(s_axis_a_tvalid), 32'(tbl[i].e_av));
            check($sformatf("row%0d b_tvalid", i), 32'(s_axis_b_tvalid), 32'(tbl[i].e_bv));
            check($sformatf("row%0d a_tdata", i), s_axis_a_tdata, tbl[i].e_ad);
            check($sformatf("row%0d b_tdata", i), s_axis_b_tdata, tbl[i].e_bd);
            check($sformatf("row%0d fifo_level", i), 32'(fifo_level), 32'(tbl[i].e_lvl));
            check($sformatf("row%0d outstanding", i), 32'(outstanding), 32'(tbl[i].e_out));
            check($sformatf("row%0d err", i), 32'(err_unexpected), 32'(tbl[i].e_err));
            check($sformatf("row%0d res_valid", i), 32'(res_valid), 32'(tbl[i].rv));
            check($sformatf("row%0d res_data", i), res_data, tbl[i].rd);
            check($sformatf("row%0d m_tready", i), 32'(m_axis_result_tready), 32'(tbl[i].rr));
            cyc();
        end

        // FIFO fill with the core stalled, then full-rate drain
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_a = 32'h100 + 32'(i); in_b = 32'h200 + 32'(i);
            #1;
            check($sformatf("fill%0d in_ready", i), 32'(in_ready), (i < 9) ? 1 : 0);
            check($sformatf("fill%0d fifo_level", i), 32'(fifo_level), (i == 0) ? 0 : 32'(i - 1));
            cyc();
        end
        in_valid = 1'b0;
        #1;
        check("full fifo_level", 32'(fifo_level), 8);
        check("full a_tdata", s_axis_a_tdata, 32'h100);
        base = issue_cnt;
        s_axis_a_tready = 1'b1; s_axis_b_tready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            #1;
            check($sformatf("b2b%0d a_tvalid", k), 32'(s_axis_a_tvalid), 1);
            check($sformatf("b2b%0d b_tvalid", k), 32'(s_axis_b_tvalid), 1);
            check($sformatf("b2b%0d a_tdata", k), s_axis_a_tdata, 32'h100 + 32'(k));
            check($sformatf("b2b%0d b_tdata", k), s_axis_b_tdata, 32'h200 + 32'(k));
            cyc();
        end
        #1;
        check("b2b issued", 32'(issue_cnt - base), 9);
        check("b2b idle a_tvalid", 32'(s_axis_a_tvalid), 0);
        check("b2b fifo_level", 32'(fifo_level), 0);
        check("b2b outstanding", 32'(outstanding), 9);
        m_axis_result_tvalid = 1'b1; res_ready = 1'b1;
        repeat (9) cyc();
        m_axis_result_tvalid = 1'b0;
        #1;
        check("drain outstanding", 32'(outstanding), 0);
        check("drain err", 32'(err_unexpected), 0);

        // Credit limit: results withheld, 20 pairs offered
        base = issue_cnt;
        for (int p = 0; p < 20; p++) begin
            in_valid = 1'b1; in_a = 32'h300 + 32'(p); in_b = 32'h400 + 32'(p);
            #1;
            check($sformatf("credit push%0d in_ready", p), 32'(in_ready), 1);
            cyc();
        end
        in_valid = 1'b0;
        repeat (10) cyc();
        check("credit issued", 32'(issue_cnt - base), 16);
        check("credit outstanding", 32'(outstanding), 16);
        check("credit fifo_level", 32'(fifo_level), 4);
        check("credit a_tvalid", 32'(s_axis_a_tvalid), 0);
        m_axis_result_tvalid = 1'b1; res_ready = 1'b1;
        cyc();
        m_axis_result_tvalid = 1'b0;
        repeat (10) cyc();
        check("credit +1 issued", 32'(issue_cnt - base), 17);
        check("credit +1 outstanding", 32'(outstanding), 16);
        check("credit +1 fifo_level", 32'(fifo_level), 3);

        // Reset pulse between phases
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        check("mid rst outstanding", 32'(outstanding), 0);
        check("mid rst fifo_level", 32'(fifo_level), 0);
        drive(0, 0, 0, 1, 1, 0, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        cyc();

        // Same-cycle retire and result at outstanding=3
        for (int p = 0; p < 3; p++) begin
            in_valid = 1'b1; in_a = 32'h500 + 32'(p); in_b = 32'h600 + 32'(p);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        cyc();
        check("sc outstanding pre", 32'(outstanding), 3);
        drive(1, OPC, OPD, 1, 0, 0, 0);
        cyc();
        in_valid = 1'b0;
        #1;
        check("sc a_tvalid load", 32'(s_axis_a_tvalid), 1);
        check("sc b_tvalid load", 32'(s_axis_b_tvalid), 1);
        cyc();
        check("sc a_tvalid split", 32'(s_axis_a_tvalid), 0);
        check("sc b_tvalid split", 32'(s_axis_b_tvalid), 1);
        check("sc outstanding mid", 32'(outstanding), 3);
        s_axis_b_tready = 1'b1; m_axis_result_tvalid = 1'b1; res_ready = 1'b1;
        cyc();
        m_axis_result_tvalid = 1'b0;
        #1;
        check("sc outstanding net0", 32'(outstanding), 3);
        check("sc b_tvalid done", 32'(s_axis_b_tvalid), 0);
        m_axis_result_tvalid = 1'b1;
        repeat (3) cyc();
        m_axis_result_tvalid = 1'b0;
        #1;
        check("sc drain outstanding", 32'(outstanding), 0);
        check("sc drain err", 32'(err_unexpected), 0);

        // Unexpected result with nothing in flight
        m_axis_result_tvalid = 1'b1;
        cyc();
        m_axis_result_tvalid = 1'b0;
        #1;
        check("unexp err", 32'(err_unexpected), 1);
        check("unexp outstanding", 32'(outstanding), 0);
        repeat (5) cyc();
        check("unexp err sticky", 32'(err_unexpected), 1);

        // Asynchronous reset in the middle of an issue
        drive(1, 32'h700, 32'h800, 1, 1, 0, 0);
        cyc();
        in_a = 32'h701; in_b = 32'h801;
        cyc();
        in_valid = 1'b0;
        cyc();
        check("ar outstanding pre", 32'(outstanding), 2);
        s_axis_a_tready = 1'b0; s_axis_b_tready = 1'b0;
        for (int p = 0; p < 5; p++) begin
            in_valid = 1'b1; in_a = 32'h900 + 32'(p); in_b = 32'ha00 + 32'(p);
            cyc();
        end
        in_valid = 1'b0;
        #1;
        check("ar fifo_level pre", 32'(fifo_level), 4);
        check("ar a_tvalid pre", 32'(s_axis_a_tvalid), 1);
        #2;
        aresetn = 1'b0;
        #1;
        check("ar a_tvalid", 32'(s_axis_a_tvalid), 0);
        check("ar b_tvalid", 32'(s_axis_b_tvalid), 0);
        check("ar fifo_level", 32'(fifo_level), 0);
        check("ar outstanding", 32'(outstanding), 0);
        check("ar err", 32'(err_unexpected), 0);
        check("ar b_tdata", s_axis_b_tdata, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        cyc();
        drive(1, OPA, OPB, 1, 1, 0, 0);
        #1;
        check("post in_ready", 32'(in_ready), 1);
        check("post a_tvalid idle", 32'(s_axis_a_tvalid), 0);
        cyc();
        in_valid = 1'b0;
        #1;
        check("post a_tvalid", 32'(s_axis_a_tvalid), 1);
        check("post a_tdata", s_axis_a_tdata, OPA);
        check("post b_tdata", s_axis_b_tdata, OPB);
        check("post fifo_level", 32'(fifo_level), 0);
        cyc();
        check("post outstanding", 32'(outstanding), 1);
        check("post b_tvalid done", 32'(s_axis_b_tvalid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
